ldl_cdc_hand_rx_v1: RTL and testbench
=====================================

Name: ldl_cdc_hand_rx_v1

Overview:
- Receiving endpoint of the toggle req/ack CDC handshake, living entirely in the rx clock domain.
- Synchronises the sender's request toggle and captures the quasi-static data bus.
- Presents the word as a valid/ready stream to local logic and returns an acknowledge toggle once the word is consumed.
- Pairs with a tx-side endpoint that holds din stable from req toggle until ack toggle.

Parameters:
- DW, 8: data width.
- CW, 8: width of the word counter and timeout counter.
- LEVEL, 2: synchroniser depth for req_tgl; minimum 2.

Ports:
- rx_clk  in  1  sole clock.
- rx_rst  in  1  reset, asynchronous, active-low.
- req_tgl  in  1  request toggle from the tx domain; asynchronous.
- din  in  DW  data from the tx domain; stable while a request is outstanding.
- dout  out  DW  captured word.
- dout_vld  out  1  word available.
- dout_rdy  in  1  consumer accepts when dout_vld & dout_rdy.
- ack_tgl  out  1  acknowledge toggle back to the tx domain; registered, no combinational path.
- word_cnt  out  CW  count of accepted words; wraps.
- timeout  in  CW  consumer acceptance limit in cycles; 0 disables. Used only with the optional feature.
- err_tout  out  1  one-cycle pulse when a word is dropped on timeout.

Behaviour:
- Reset (rx_rst low, async) clears:
  - all LEVEL synchroniser flops, req_seen, ack_tgl, dout, dout_vld, word_cnt, timer and err_tout to 0;
  - FSM to IDLE.
- Release of reset is not synchronised here; the integrating level provides that.
- req_s is the last synchroniser stage. new_req = (req_s != req_seen).
- FSM states:
  - IDLE:
    - on new_req: dout <= din, dout_vld <= 1, go to HOLD;
    - din is sampled only in this cycle.
  - HOLD:
    - dout_vld = 1 and dout is frozen;
    - on dout_vld & dout_rdy: dout_vld <= 0, ack_tgl <= ~ack_tgl, req_seen <= req_s, word_cnt <= word_cnt + 1 (mod 2^CW), go to IDLE.
- new_req is ignored outside IDLE.
  - A second req toggle during HOLD is a sender protocol violation.
  - It is absorbed: req_seen takes req_s at acceptance, so two toggles cancel and no word is produced.
- Latency:
  - req_tgl edge to dout_vld high: LEVEL+1 rx_clk cycles.
  - Acceptance to ack_tgl toggle: 1 cycle.
- dout_rdy already high when dout_vld rises: accepted that same cycle; next IDLE is the following cycle.
- Throughput is bounded by the round trip: at most one word per handshake.
- dout_vld never drops without acceptance, except on timeout or reset.
- dout holds its value after acceptance until the next capture.
- Reset mid-HOLD discards the word; no ack is issued, and the sender must be reset alongside.

Optional Feature:
- Macro: LDL_CDC_HAND_RX_TOUT_EN.
- Defined:
  - A CW-bit timer clears on entry to HOLD and increments each HOLD cycle without acceptance.
  - When timeout != 0 and the timer reaches timeout - 1 without acceptance, the next cycle:
    - drops the word: dout_vld <= 0;
    - toggles ack_tgl and updates req_seen;
    - pulses err_tout for 1 cycle;
    - does not increment word_cnt;
    - returns to IDLE.
  - Acceptance in the same cycle as expiry wins: counted, no error.
- Undefined: no timer logic; timeout is ignored; err_tout is tied 0; HOLD waits indefinitely.

Decomposition:
- Shared package (ldl_cdc_pkg):
  - FSM state enum (IDLE, HOLD);
  - LEVEL minimum constant (2), checked with an elaboration-time assertion.
- One sub-module, ldl_sync_bit_v1: LEVEL-deep single-bit synchroniser, async active-low reset to 0. Reusable by the tx-side endpoint for ack_tgl.
- The FSM, capture register and counters stay in the top.

Test Plan:
- Reset: rx_rst low mid-traffic -> dout = 0, dout_vld = 0, ack_tgl = 0, word_cnt = 0 immediately (async); no ack after release.
- Single word, LEVEL = 2, dout_rdy = 1: din = 8'hA5, toggle req_tgl -> dout_vld high 3 cycles later with dout = A5; ack_tgl toggles 1 cycle after; word_cnt = 1.
- Backpressure: dout_rdy = 0 for 10 cycles, din changed after capture -> dout stays A5 and dout_vld stays high; ack_tgl toggles only 1 cycle after rdy rises.
- Stream with CW = 8: 257 full handshakes with din = index -> every word matches in order; word_cnt wraps to 1.
- Protocol violation: two req toggles during HOLD -> one word delivered; after acceptance, no spurious new word.
- With LDL_CDC_HAND_RX_TOUT_EN, timeout = 5, dout_rdy = 0 -> dout_vld drops after 5 HOLD cycles; err_tout pulses once; ack_tgl toggles; word_cnt unchanged. With timeout = 0 -> waits indefinitely.

Source files
------------

// File: rtl/ldl_cdc_pkg.sv
// rtl/ldl_cdc_pkg.sv - shared types and limits for the toggle req/ack CDC endpoints
package ldl_cdc_pkg;

    // Receiver handshake state: waiting for a request, or holding a captured word
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rx_state_e;

    // Fewer than two flops gives no metastability settling time
    localparam int LEVEL_MIN = 2;

endpackage

// File: rtl/ldl_sync_bit_v1.sv
// rtl/ldl_sync_bit_v1.sv - LEVEL-deep single-bit synchroniser, async active-low reset to 0
module ldl_sync_bit_v1 #(
    parameter int LEVEL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [LEVEL-1:0] sync_q;

    // Shift the asynchronous bit through the flop chain; the last stage is safe to use
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[LEVEL-2:0], d_i};
        end
    end

    assign q_o = sync_q[LEVEL-1];

endmodule

// File: rtl/ldl_cdc_hand_rx_v1.sv
// rtl/ldl_cdc_hand_rx_v1.sv - rx endpoint of toggle req/ack CDC handshake; optional timeout via LDL_CDC_HAND_RX_TOUT_EN
module ldl_cdc_hand_rx_v1 #(
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int LEVEL = 2
) (
    input  logic          rx_clk,
    input  logic          rx_rst,
    input  logic          req_tgl,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic          ack_tgl,
    output logic [CW-1:0] word_cnt,
    input  logic [CW-1:0] timeout,
    output logic          err_tout
);

    import ldl_cdc_pkg::*;

    localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};

    if (LEVEL < LEVEL_MIN) begin : g_level_chk
        $error("ldl_cdc_hand_rx_v1: LEVEL must be at least 2");
    end

    rx_state_e     state_q, state_d;
    logic          req_s;
    logic          req_seen_q, req_seen_d;
    logic          ack_q, ack_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          vld_q, vld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          new_req;
    logic          accept;
    logic          expire;

    ldl_sync_bit_v1 #(
        .LEVEL (LEVEL)
    ) u_req_sync (
        .clk   (rx_clk),
        .rst_n (rx_rst),
        .d_i   (req_tgl),
        .q_o   (req_s)
    );

    assign new_req = (req_s != req_seen_q);
    assign accept  = vld_q & dout_rdy;

`ifdef LDL_CDC_HAND_RX_TOUT_EN
    logic [CW-1:0] timer_q, timer_d;
    logic          err_q, err_d;

    // The word is abandoned once the consumer has stalled for timeout cycles
    assign expire = (state_q == HOLD) && (timeout != '0) && (timer_q == (timeout - ONE_CW));

    // Timer and error pulse registers
    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    // Timer clears on capture, counts stalled HOLD cycles; pulse error when dropping
    always_comb begin
        timer_d = timer_q;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            if (new_req) begin
                timer_d = '0;
            end
        end else if (!accept) begin
            if (expire) begin
                err_d = 1'b1;
            end else begin
                timer_d = timer_q + ONE_CW;
            end
        end
    end

    assign err_tout = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout;
    assign expire         = 1'b0;
    assign err_tout       = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: capture on a fresh request, release on acceptance or expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (new_req) state_d = HOLD;
            HOLD:    if (accept || expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: capture word, hand back ack toggle, count accepted words
    always_comb begin
        req_seen_d = req_seen_q;
        ack_d      = ack_q;
        dout_d     = dout_q;
        vld_d      = vld_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (new_req) begin
                    dout_d = din;
                    vld_d  = 1'b1;
                end
            end
            HOLD: begin
                // req_seen follows req_s only here, so toggles seen during HOLD cancel out
                if (accept) begin
                    vld_d      = 1'b0;
                    ack_d      = ~ack_q;
                    req_seen_d = req_s;
                    cnt_d      = cnt_q + ONE_CW;
                end else if (expire) begin
                    vld_d      = 1'b0;
                    ack_d      = ~ack_q;
                    req_seen_d = req_s;
                end
            end
            default: begin
                vld_d = 1'b0;
            end
        endcase
    end

    // Handshake and datapath registers
    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            req_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            dout_q     <= '0;
            vld_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            req_seen_q <= req_seen_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
            vld_q      <= vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign ack_tgl  = ack_q;
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_ldl_cdc_hand_rx_v1.sv
// tb/tb_ldl_cdc_hand_rx_v1.sv - scoreboard bench for ldl_cdc_hand_rx_v1
module tb_ldl_cdc_hand_rx_v1;

    logic       rx_clk;
    logic       rx_rst;
    logic       req_tgl;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_rdy;
    logic       ack_tgl;
    logic [7:0] word_cnt;
    logic [7:0] timeout;
    logic       err_tout;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       exp_ack;

    ldl_cdc_hand_rx_v1 #(
        .DW    (8),
        .CW    (8),
        .LEVEL (2)
    ) dut (
        .rx_clk   (rx_clk),
        .rx_rst   (rx_rst),
        .req_tgl  (req_tgl),
        .din      (din),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .ack_tgl  (ack_tgl),
        .word_cnt (word_cnt),
        .timeout  (timeout),
        .err_tout (err_tout)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Issue one request toggle; push the word when it is expected to be accepted
    task automatic send(input logic [7:0] d, input bit expect_word);
        din     = d;
        req_tgl = ~req_tgl;
        if (expect_word) exp_q.push_back(d);
    endtask

    task automatic wait_ack(input string name, input int budget);
        int n = 0;
        while (ack_tgl !== exp_ack && n < budget) begin
            tick();
            n++;
        end
        check(name, ack_tgl, exp_ack);
    endtask

    // Monitor: every accepted word must match the oldest expected one
    always @(negedge rx_clk) begin
        if (rx_rst && dout_vld && dout_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected got %0h expected none", dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL mon_data got %0h expected %0h", dout, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rx_rst   = 1'b0;
        req_tgl  = 1'b0;
        din      = 8'h00;
        dout_rdy = 1'b0;
        timeout  = 8'd0;
        exp_ack  = 1'b0;
        ticks(2);
        check("rst_vld", dout_vld, 0);
        check("rst_dout", dout, 0);
        check("rst_ack", ack_tgl, 0);
        check("rst_cnt", word_cnt, 0);
        check("rst_err", err_tout, 0);
        rx_rst = 1'b1;
        ticks(2);

        // Single word, consumer ready: LEVEL+1 latency, ack one cycle later
        dout_rdy = 1'b1;
        send(8'hA5, 1);
        ticks(2);
        check("lat_vld_early", dout_vld, 0);
        tick();
        check("lat_vld", dout_vld, 1);
        check("lat_dout", dout, 8'hA5);
        check("lat_ack_hold", ack_tgl, exp_ack);
        tick();
        exp_ack = ~exp_ack;
        check("single_ack", ack_tgl, exp_ack);
        check("single_vld_low", dout_vld, 0);
        check("single_cnt", word_cnt, 1);

        // Backpressure: word frozen, ack only after ready rises
        dout_rdy = 1'b0;
        send(8'hA5, 1);
        ticks(3);
        check("bp_vld", dout_vld, 1);
        din = 8'h3C;
        ok  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dout_vld !== 1'b1 || dout !== 8'hA5 || ack_tgl !== exp_ack) ok = 1'b0;
        end
        check("bp_stall_stable", ok, 1);
        dout_rdy = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        check("bp_ack", ack_tgl, exp_ack);
        check("bp_dout_after", dout, 8'hA5);
        check("bp_cnt", word_cnt, 2);

        // Reset mid-HOLD: asynchronous clear, no ack afterwards
        dout_rdy = 1'b0;
        send(8'h77, 1);
        ticks(3);
        check("mrst_vld_pre", dout_vld, 1);
        #2;
        rx_rst  = 1'b0;
        req_tgl = 1'b0;
        #1;
        check("mrst_dout", dout, 0);
        check("mrst_vld", dout_vld, 0);
        check("mrst_ack", ack_tgl, 0);
        check("mrst_cnt", word_cnt, 0);
        exp_q.delete();
        exp_ack = 1'b0;
        @(posedge rx_clk);
        #1;
        rx_rst = 1'b1;
        ok     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_tgl !== 1'b0 || dout_vld !== 1'b0) ok = 1'b0;
        end
        check("mrst_quiet", ok, 1);

        // Stream of 257 words; counter wraps to 1
        dout_rdy = 1'b1;
        for (int i = 0; i < 257; i++) begin
            logic [7:0] d;
            d = 8'(i);
            send(d, 1);
            exp_ack = ~exp_ack;
            wait_ack("stream_ack", 12);
        end
        check("stream_cnt_wrap", word_cnt, 1);

        // Protocol violation: two extra toggles during HOLD cancel out
        dout_rdy = 1'b0;
        send(8'h5A, 1);
        ticks(3);
        check("viol_vld", dout_vld, 1);
        req_tgl = ~req_tgl;
        ticks(3);
        req_tgl = ~req_tgl;
        ticks(4);
        check("viol_dout", dout, 8'h5A);
        dout_rdy = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        check("viol_ack", ack_tgl, exp_ack);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dout_vld !== 1'b0) ok = 1'b0;
        end
        check("viol_no_spurious", ok, 1);
        check("viol_cnt", word_cnt, 2);

`ifdef LDL_CDC_HAND_RX_TOUT_EN
        // Timeout = 5: drop after five stalled HOLD cycles
        dout_rdy = 1'b0;
        timeout  = 8'd5;
        send(8'hC3, 0);
        ticks(3);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (dout_vld !== 1'b1 || err_tout !== 1'b0) ok = 1'b0;
            tick();
        end
        if (dout_vld !== 1'b1) ok = 1'b0;
        check("tout_hold5", ok, 1);
        tick();
        exp_ack = ~exp_ack;
        check("tout_vld_drop", dout_vld, 0);
        check("tout_err", err_tout, 1);
        check("tout_ack", ack_tgl, exp_ack);
        tick();
        check("tout_err_pulse", err_tout, 0);
        check("tout_cnt", word_cnt, 2);

        // Acceptance on the expiry cycle wins
        send(8'hD2, 1);
        ticks(3);
        ticks(4);
        dout_rdy = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        check("race_ack", ack_tgl, exp_ack);
        check("race_err", err_tout, 0);
        check("race_cnt", word_cnt, 3);
        dout_rdy = 1'b0;
        timeout  = 8'd0;
        send(8'hE1, 1);
        ticks(3);
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (dout_vld !== 1'b1 || err_tout !== 1'b0 || ack_tgl !== exp_ack) ok = 1'b0;
        end
        check("tout0_wait", ok, 1);
        dout_rdy = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        check("tout0_ack", ack_tgl, exp_ack);
        check("tout0_cnt", word_cnt, 4);
`else
        // Feature disabled: timeout is ignored, HOLD waits indefinitely
        dout_rdy = 1'b0;
        timeout  = 8'd5;
        send(8'hC3, 1);
        ticks(3);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dout_vld !== 1'b1 || err_tout !== 1'b0 || ack_tgl !== exp_ack) ok = 1'b0;
        end
        check("notout_wait", ok, 1);
        dout_rdy = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        check("notout_ack", ack_tgl, exp_ack);
        check("notout_cnt", word_cnt, 3);
`endif

        ticks(3);
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
